// File: rtl/stream_pkg.sv
// Shared width defaults, beat struct and the word/beat ratio legality check
// for the stream width converters.
package stream_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int BYTE_WIDTH = 8;

    typedef struct packed {
        logic [BYTE_WIDTH-1:0] data;
        logic                  last;
    } beat_t;

    // A word must split into a whole number of beats, and at least two of them.
    function automatic bit ratio_ok(input int in_w, input int out_w);
        return (out_w > 0) && ((in_w % out_w) == 0) && ((in_w / out_w) >= 2);
    endfunction

endpackage

// File: rtl/stream_downsizer_if.sv
// Word-in / beat-out valid-ready bundle for stream_downsizer.
// slave = the converter's view, master = the upstream/downstream environment.
interface stream_downsizer_if
    import stream_pkg::*;
#(
    parameter int IN_WIDTH  = DATA_WIDTH,
    parameter int OUT_WIDTH = BYTE_WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/stream_downsizer.sv
// Splits each IN_WIDTH word into RATIO OUT_WIDTH beats (LSB first; MSB first with STREAM_DOWNSIZER_MSB_FIRST_EN).
// Latency: beat 0 is presented the cycle after the word is accepted; full 1 beat/cycle throughput.
// Backpressure: beats hold while out_ready=0; in_ready only while empty or as the final beat is taken.
module stream_downsizer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH  = DATA_WIDTH,
    parameter int OUT_WIDTH = BYTE_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_downsizer_if.slave   bus
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    if (!ratio_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
        $error("stream_downsizer: IN_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
    end

    logic [IN_WIDTH-1:0] word_q;
    logic                last_q;
    logic [CW-1:0]       cnt_q;
    logic                valid_q;
    logic                at_end;
    logic                accept;

    assign at_end       = (cnt_q == CW'(RATIO - 1));
    // Refill in the same cycle the final beat leaves, so there is no bubble.
    assign bus.in_ready = ~valid_q | (bus.out_ready & at_end);
    assign accept       = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (accept) begin
            word_q  <= bus.in_data;
            last_q  <= bus.in_last;
            cnt_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && bus.out_ready) begin
            if (at_end) begin
                valid_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
`ifdef STREAM_DOWNSIZER_MSB_FIRST_EN
        bus.out_data = word_q[IN_WIDTH - 1 - int'(cnt_q) * OUT_WIDTH -: OUT_WIDTH];
`else
        bus.out_data = word_q[int'(cnt_q) * OUT_WIDTH +: OUT_WIDTH];
`endif
    end

    assign bus.out_valid = valid_q;
    assign bus.out_last  = valid_q & last_q & at_end;

endmodule

// File: tb/tb_stream_downsizer.sv
// Randomised scoreboard bench for stream_downsizer: accepted words are expanded
// into expected beats by a word-level model and compared as beats leave the DUT.
module tb_stream_downsizer;
    localparam int IW    = 32;
    localparam int OW    = 8;
    localparam int RATIO = IW / OW;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
        logic          fin;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    exp_t exp_q[$];

    stream_downsizer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) sif ();

    stream_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] beat_of(input logic [IW-1:0] w, input int k);
`ifdef STREAM_DOWNSIZER_MSB_FIRST_EN
        return OW'(w >> (OW * (RATIO - 1 - k)));
`else
        return OW'(w >> (OW * k));
`endif
    endfunction

    // Hold the word until the DUT takes it; expected beats enter the scoreboard on acceptance.
    task automatic send_word(input logic [IW-1:0] w, input logic last);
        bit taken = 0;
        sif.in_valid = 1'b1;
        sif.in_data  = w;
        sif.in_last  = last;
        for (int c = 0; c < 200 && !taken; c++) begin
            @(negedge clk);
            if (sif.in_ready) begin
                taken = 1;
                for (int k = 0; k < RATIO; k++)
                    exp_q.push_back('{beat_of(w, k), last && (k == RATIO - 1), k == RATIO - 1});
            end
            @(posedge clk);
            #1;
        end
        if (!taken) check("accept_timeout", 0, 1);
        sif.in_valid = 1'b0;
    endtask

    initial begin
        int ph = 0;
        sif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: sif.out_ready = 1'b1;
                1: begin
                    sif.out_ready = (ph % 4 == 0) || (ph % 4 == 3);
                    ph++;
                end
                default: sif.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares beats as they handshake and checks hold-while-stalled.
    initial begin
        logic          stalled = 0;
        logic [OW-1:0] held_d = '0;
        logic          held_l = 0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("hold_valid", sif.out_valid, 1);
                    check("hold_data", sif.out_data, held_d);
                    check("hold_last", sif.out_last, held_l);
                end
                stalled = 0;
                if (sif.out_valid && sif.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", sif.out_data, 'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", sif.out_data, e.data);
                        check("beat_last", sif.out_last, e.last);
                        check("in_ready_on_beat", sif.in_ready, e.fin);
                    end
                end else if (sif.out_valid) begin
                    check("in_ready_stalled", sif.in_ready, 0);
                    stalled = 1;
                    held_d  = sif.out_data;
                    held_l  = sif.out_last;
                end
            end
        end
    end

    initial begin
        bit seen;
        sif.in_valid = 1'b0;
        sif.in_data  = '0;
        sif.in_last  = 1'b0;

        // Reset values
        #12;
        check("rst_out_valid", sif.out_valid, 0);
        check("rst_out_data", sif.out_data, 0);
        check("rst_out_last", sif.out_last, 0);
        check("rst_in_ready", sif.in_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_out_valid", sif.out_valid, 0);
            check("idle_in_ready", sif.in_ready, 1);
        end

        // Single word, always ready; beat 0 the cycle after acceptance
        @(posedge clk);
        #1;
        send_word(32'hA1B2C3D4, 1'b0);
        check("latency_valid", sif.out_valid, 1);
        check("latency_beat0", sif.out_data, beat_of(32'hA1B2C3D4, 0));
        repeat (6) @(posedge clk);
        #1;

        // Back-to-back words must stream with no gap
        fork
            begin
                send_word(32'h11223344, 1'b0);
                send_word(32'h55667788, 1'b1);
            end
            begin
                seen = 0;
                for (int c = 0; c < 20 && !seen; c++) begin
                    @(negedge clk);
                    seen = sif.out_valid;
                end
                check("b2b_start", seen, 1);
                for (int i = 1; i < 2 * RATIO; i++) begin
                    @(negedge clk);
                    check("b2b_nogap", sif.out_valid, 1);
                end
                @(negedge clk);
                check("b2b_end", sif.out_valid, 0);
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Stall pattern 1,0,0,1
        rdy_mode = 1;
        send_word(32'hDEADBEEF, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("stall_drained", exp_q.size(), 0);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Async reset mid-word
        send_word(32'hCAFEF00D, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", sif.out_valid, 0);
        check("midrst_out_data", sif.out_data, 0);
        check("midrst_in_ready", sif.in_ready, 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_beats", sif.out_valid, 0);
            check("post_rst_in_ready", sif.in_ready, 1);
        end
        @(posedge clk);
        #1;

        // Random traffic
        rdy_mode = 2;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            send_word($urandom, 1'($urandom_range(0, 1)));
        end
        rdy_mode = 0;
        for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check("final_drained", exp_q.size(), 0);
        @(negedge clk);
        check("final_idle", sif.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stream_downsizer.md
Name: stream_downsizer

Overview:
- Valid/ready width converter placed directly downstream of pipeline_reg.
- Accepts one IN_WIDTH word per handshake and emits it as RATIO consecutive OUT_WIDTH beats on a valid/ready output.
- Carries a packet-end marker: out_last is asserted on the final beat of a word tagged in_last.
- Sustains full throughput: a new word is accepted in the same cycle its predecessor's last beat is consumed.

Parameters:
- IN_WIDTH, 32, input word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, output beat width.
- RATIO (localparam), IN_WIDTH/OUT_WIDTH, beats per word; must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  IN_WIDTH  upstream word
- in_last  input  1  word is last of packet
- out_valid  output  1  beat valid
- out_ready  input  1  downstream accepts beat
- out_data  output  OUT_WIDTH  current beat
- out_last  output  1  beat is final beat of a last word

Behaviour:
- Storage: word register, last flag register, beat counter (clog2(RATIO) bits), valid register.
- States: EMPTY (valid_reg=0) and BUSY (valid_reg=1).
- Reset (async, rst_n=0): valid_reg=0, counter=0, word=0, last flag=0. Outputs during reset: out_valid=0, out_data=0, out_last=0, in_ready=1.
- out_valid = valid_reg.
- out_data = word slice selected by counter; beat 0 = bits [OUT_WIDTH-1:0] (LSB-first by default).
- out_last = valid_reg & last flag & (counter==RATIO-1).
- in_ready = ~valid_reg | (out_ready & counter==RATIO-1). Combinational from out_ready; no dependence on in_valid.
- Latency: a word accepted at edge N presents beat 0 in the cycle after edge N.
- Transfer on in_valid & in_ready:
  - word <= in_data; last flag <= in_last; counter <= 0; valid_reg <= 1.
  - This has priority over the beat-advance rules below.
- Beat advance on out_valid & out_ready, with no accept that cycle:
  - If counter < RATIO-1: counter increments.
  - If counter == RATIO-1: valid_reg <= 0 and counter <= 0 (back to EMPTY).
- Simultaneous final-beat consume and new word accept: word reloaded, counter=0, valid_reg stays 1. No bubble, so steady-state throughput is 1 beat per cycle.
- out_valid=1 with out_ready=0: out_data, out_last and counter hold stable. The output is never withdrawn.
- in_valid with in_ready=0: word not taken. Upstream must hold.
- Counter width: clog2(RATIO); RATIO-1 is the wrap point. No other wrap is permitted.
- Reset mid-word: the in-flight word is discarded and no partial beats are emitted after release.

Optional Feature:
- Macro: STREAM_DOWNSIZER_MSB_FIRST_EN.
- Defined: beat k = word bits [IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH], i.e. most-significant slice first.
- Undefined: LSB-first order as specified above.
- Handshake, counter, latency and out_last timing are identical in both builds.

Decomposition:
- Shared package stream_pkg holds:
  - default width constants (DATA_WIDTH=32, BYTE_WIDTH=8);
  - a typedef for the {data,last} beat struct;
  - the RATIO legality check function.
- Single module; no sub-module is needed. Slice selection is an indexed part-select on the counter.
- The block instantiates downstream of pipeline_reg without glue logic.

Test Plan:
- Reset, then word 0xA1B2C3D4 with in_last=0 and out_ready held 1 -> out_data 0xD4,0xC3,0xB2,0xA1 on 4 consecutive cycles; out_last=0 throughout; in_ready=1 during the 4th beat.
- Back-to-back words 0x11223344 (last=0) then 0x55667788 (last=1), in_valid and out_ready continuously 1 -> 8 beats with no gap; out_last=1 only on beat 0x55.
- Random out_ready stalls (pattern 1,0,0,1,...) during word 0xDEADBEEF -> data and out_last stable while stalled; no beat lost or duplicated; in_ready=0 until the last beat handshakes.
- Assert rst_n=0 after beat 1 of 0xCAFEF00D -> out_valid=0 immediately (async). After release: in_ready=1, counter 0, no residual beats.
- Build with STREAM_DOWNSIZER_MSB_FIRST_EN and send word 0xA1B2C3D4 -> beats 0xA1,0xB2,0xC3,0xD4 with timing identical to the default build.
- Idle: in_valid=0 for 10 cycles after reset -> out_valid stays 0 and in_ready stays 1.
